// File: rtl/button_op_ctrl.sv
// Pushbutton front end: sync + debounce four buttons, emit one-cycle press events,
// and run the OFF/ON power FSM that latches the selected arithmetic operation.
module button_op_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_lig,
    input  logic       b_soma,
    input  logic       b_sub,
    input  logic       b_multi,
    output logic       EN,
    output logic [1:0] op,
    output logic       op_strobe,
    output logic [3:0] press
);

    localparam int unsigned   CW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    RAW_REL = {4{BTN_ACTIVE_LOW}};

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    logic [3:0]         raw;
    logic [3:0]         sync1_q, sync2_q;
    logic [3:0]         lvl;
    logic [3:0]         deb_q, deb_d;
    logic [3:0]         deb_dly_q;
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [3:0]         press_q;

    state_t     state_q;
    logic       en_q;
    logic [1:0] op_q;
    logic       strobe_q;

    assign raw = {b_multi, b_sub, b_soma, b_lig};
    // Sync flops keep raw polarity; normalise to 1 = pressed only after the second stage.
    assign lvl = sync2_q ^ RAW_REL;

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (lvl[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = ~deb_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= RAW_REL;
            sync2_q   <= RAW_REL;
            deb_q     <= '0;
            deb_dly_q <= '0;
            cnt_q     <= '0;
            press_q   <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
            press_q   <= deb_q & ~deb_dly_q;
        end
    end

    // Power press beats any op press; among ops add > sub > mul, losers are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_OFF;
            en_q     <= 1'b0;
            op_q     <= 2'b00;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                ST_OFF: begin
                    if (press_q[0]) begin
                        state_q <= ST_ON;
                        en_q    <= 1'b1;
                        op_q    <= 2'b00;
                    end
                end
                ST_ON: begin
                    if (press_q[0]) begin
                        state_q <= ST_OFF;
                        en_q    <= 1'b0;
                        op_q    <= 2'b00;
                    end else if (press_q[1]) begin
                        op_q     <= 2'b01;
                        strobe_q <= 1'b1;
                    end else if (press_q[2]) begin
                        op_q     <= 2'b10;
                        strobe_q <= 1'b1;
                    end else if (press_q[3]) begin
                        op_q     <= 2'b11;
                        strobe_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    en_q    <= 1'b0;
                    op_q    <= 2'b00;
                end
            endcase
        end
    end

    assign EN        = en_q;
    assign op        = op_q;
    assign op_strobe = strobe_q;
    assign press     = press_q;

endmodule

// File: tb/tb_button_op_ctrl.sv
// Directed bench for button_op_ctrl with a 4-cycle debounce and active-low buttons.
module tb_button_op_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_n;   // {multi, sub, soma, lig}, 0 = pressed
    logic       EN;
    logic [1:0] op;
    logic       op_strobe;
    logic [3:0] press;

    int n_vec = 0;
    int n_bad = 0;

    button_op_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .b_lig    (btn_n[0]),
        .b_soma   (btn_n[1]),
        .b_sub    (btn_n[2]),
        .b_multi  (btn_n[3]),
        .EN       (EN),
        .op       (op),
        .op_strobe(op_strobe),
        .press    (press)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press the buttons in mask; returns one cycle after the press event so FSM outputs are visible.
    task automatic tap(input string tag, input logic [3:0] mask);
        btn_n = ~mask;
        cyc(6);
        check({tag, "_early"}, 32'(press), 32'h0);
        cyc(1);
        check({tag, "_press"}, 32'(press), 32'(mask));
        cyc(1);
    endtask

    task automatic check_fsm(input string tag, input logic en_exp, input logic [1:0] op_exp,
                             input logic stb_exp);
        check({tag, "_en"}, 32'(EN), 32'(en_exp));
        check({tag, "_op"}, 32'(op), 32'(op_exp));
        check({tag, "_stb"}, 32'(op_strobe), 32'(stb_exp));
    endtask

    // Releasing must produce no press events and no further strobes.
    task automatic release_all(input string tag);
        int np;
        int ns;
        np = 0;
        ns = 0;
        btn_n = 4'hF;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (press != 4'h0) np++;
            if (op_strobe) ns++;
        end
        check({tag, "_rel_press"}, 32'(np), 32'h0);
        check({tag, "_rel_stb"}, 32'(ns), 32'h0);
    endtask

    initial begin
        int np;
        int ns;

        rst   = 1'b1;
        btn_n = 4'h0;
        cyc(3);
        check_fsm("rst", 1'b0, 2'b00, 1'b0);
        check("rst_press", 32'(press), 32'h0);

        // Buttons held through reset release: one 1111 event, 7 cycles later.
        rst = 1'b0;
        cyc(6);
        check("hold_early", 32'(press), 32'h0);
        cyc(1);
        check("hold_press", 32'(press), 32'hF);
        cyc(1);
        check("hold_once", 32'(press), 32'h0);
        check_fsm("hold", 1'b1, 2'b00, 1'b0);
        release_all("hold");
        check("hold_en_kept", 32'(EN), 32'h1);

        // Three-cycle glitch on add must be rejected.
        btn_n = 4'b1101;
        cyc(3);
        btn_n = 4'hF;
        np = 0;
        ns = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (press[1]) np++;
            if (op_strobe) ns++;
        end
        check("bounce_press", 32'(np), 32'h0);
        check("bounce_stb", 32'(ns), 32'h0);
        check("bounce_op", 32'(op), 32'h0);

        // Ten-cycle hold on add: a single event and strobe.
        btn_n = 4'b1101;
        cyc(6);
        check("soma_early", 32'(press), 32'h0);
        cyc(1);
        check("soma_press", 32'(press), 32'h2);
        check("soma_stb_pre", 32'(op_strobe), 32'h0);
        cyc(1);
        check("soma_once", 32'(press), 32'h0);
        check_fsm("soma", 1'b1, 2'b01, 1'b1);
        cyc(2);
        release_all("soma");

        // Power toggling and op press while OFF.
        tap("pwr_off1", 4'b0001);
        check_fsm("pwr_off1", 1'b0, 2'b00, 1'b0);
        release_all("pwr_off1");
        tap("pwr_on", 4'b0001);
        check_fsm("pwr_on", 1'b1, 2'b00, 1'b0);
        release_all("pwr_on");
        tap("pwr_off2", 4'b0001);
        check_fsm("pwr_off2", 1'b0, 2'b00, 1'b0);
        release_all("pwr_off2");
        tap("sub_off", 4'b0100);
        check_fsm("sub_off", 1'b0, 2'b00, 1'b0);
        release_all("sub_off");

        // Op selection while ON.
        tap("on2", 4'b0001);
        check_fsm("on2", 1'b1, 2'b00, 1'b0);
        release_all("on2");
        tap("mul", 4'b1000);
        check_fsm("mul", 1'b1, 2'b11, 1'b1);
        release_all("mul");
        tap("sub", 4'b0100);
        check_fsm("sub", 1'b1, 2'b10, 1'b1);
        release_all("sub");
        tap("sub_again", 4'b0100);
        check_fsm("sub_again", 1'b1, 2'b10, 1'b1);
        release_all("sub_again");

        // Simultaneous presses.
        tap("soma_mul", 4'b1010);
        check_fsm("soma_mul", 1'b1, 2'b01, 1'b1);
        release_all("soma_mul");
        tap("lig_sub", 4'b0101);
        check_fsm("lig_sub", 1'b0, 2'b00, 1'b0);
        release_all("lig_sub");

        // Reset part-way through a debounce, button still held afterwards.
        tap("on3", 4'b0001);
        check_fsm("on3", 1'b1, 2'b00, 1'b0);
        release_all("on3");
        btn_n = 4'b0111;
        cyc(2);
        rst = 1'b1;
        #1;
        check_fsm("mid_rst", 1'b0, 2'b00, 1'b0);
        check("mid_rst_press", 32'(press), 32'h0);
        cyc(1);
        rst = 1'b0;
        cyc(6);
        check("mid_early", 32'(press), 32'h0);
        cyc(1);
        check("mid_press", 32'(press), 32'h8);
        cyc(1);
        check("mid_once", 32'(press), 32'h0);
        check_fsm("mid", 1'b0, 2'b00, 1'b0);
        release_all("mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
